// File: rtl/click_to_cell_decoder.sv
// rtl/click_to_cell_decoder.sv - mouse button/pointer front end producing one-hot cell and control pulses
module click_to_cell_decoder #(
  parameter int DEB_CYCLES = 100000,
  parameter int PULSE_LEN  = 4,
  parameter int X0         = 220,
  parameter int Y0         = 140,
  parameter int CELL       = 66,
  parameter int CW         = 10
) (
  input  logic          clk_100MHz,
  input  logic          reset,
  input  logic [CW-1:0] mouse_x,
  input  logic [CW-1:0] mouse_y,
  input  logic          btn_left,
  input  logic          btn_right,
  input  logic          btn_middle,
  output logic [8:0]    cuadro,
  output logic          randomClick,
  output logic          restart,
  output logic          erase,
  output logic          busy
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] PULSE    = 2'd2;
  localparam logic [1:0] RELEASE  = 2'd3;

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int PW = $clog2(PULSE_LEN + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [PW-1:0] PUL_LAST = PW'(PULSE_LEN - 1);

  // Two spare bits so X0+3*CELL never wraps in the comparisons
  localparam int EW = CW + 2;
  localparam logic [EW-1:0] XB0 = EW'(X0);
  localparam logic [EW-1:0] XB1 = EW'(X0 + CELL);
  localparam logic [EW-1:0] XB2 = EW'(X0 + 2 * CELL);
  localparam logic [EW-1:0] XB3 = EW'(X0 + 3 * CELL);
  localparam logic [EW-1:0] YB0 = EW'(Y0);
  localparam logic [EW-1:0] YB1 = EW'(Y0 + CELL);
  localparam logic [EW-1:0] YB2 = EW'(Y0 + 2 * CELL);
  localparam logic [EW-1:0] YB3 = EW'(Y0 + 3 * CELL);

  // Button vectors are ordered {right, middle, left}
  logic [2:0]    meta_q, sync_q;
  logic [1:0]    state_q, state_d;
  logic [2:0]    sel_q, sel_d;
  logic [DW-1:0] deb_q, deb_d;
  logic [PW-1:0] pul_q, pul_d;
  logic [8:0]    cuadro_q, cuadro_d;
  logic          rnd_q, rnd_d;
  logic          rst_q, rst_d;
  logic          era_q, era_d;

  logic [EW-1:0] xe, ye;
  logic [2:0]    col_oh, row_oh;
  logic [8:0]    cell_oh;
  logic [2:0]    prio_oh;

  // Two-flop synchronisers for the asynchronous button levels
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      meta_q <= 3'b000;
      sync_q <= 3'b000;
    end else begin
      meta_q <= {btn_right, btn_middle, btn_left};
      sync_q <= meta_q;
    end
  end

  // Map the pointer onto the board with range compares; an out-of-range axis leaves its one-hot empty
  always_comb begin
    xe        = {2'b00, mouse_x};
    ye        = {2'b00, mouse_y};
    col_oh[0] = (xe >= XB0) && (xe < XB1);
    col_oh[1] = (xe >= XB1) && (xe < XB2);
    col_oh[2] = (xe >= XB2) && (xe < XB3);
    row_oh[0] = (ye >= YB0) && (ye < YB1);
    row_oh[1] = (ye >= YB1) && (ye < YB2);
    row_oh[2] = (ye >= YB2) && (ye < YB3);
    cell_oh   = 9'd0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        cell_oh[r*3+c] = row_oh[r] & col_oh[c];
      end
    end
  end

  // Right beats middle beats left when several buttons arrive together
  always_comb begin
    if (sync_q[2])      prio_oh = 3'b100;
    else if (sync_q[1]) prio_oh = 3'b010;
    else                prio_oh = 3'b001;
  end

  // Next-state logic: debounce the chosen button, emit one fixed pulse, then wait for full release
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    deb_d    = deb_q;
    pul_d    = pul_q;
    cuadro_d = cuadro_q;
    rnd_d    = rnd_q;
    rst_d    = rst_q;
    era_d    = era_q;
    case (state_q)
      IDLE: begin
        if (|sync_q) begin
          sel_d   = prio_oh;
          deb_d   = '0;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (!(|(sync_q & sel_q))) begin
          state_d = IDLE;
        end else if (deb_q == DEB_LAST) begin
          // Pointer is sampled here only; later movement cannot alter the pulse
          cuadro_d = sel_q[0] ? cell_oh : 9'd0;
          rnd_d    = sel_q[0];
          era_d    = sel_q[1];
          rst_d    = sel_q[2];
          pul_d    = '0;
          state_d  = PULSE;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      PULSE: begin
        if (pul_q == PUL_LAST) begin
          cuadro_d = 9'd0;
          rnd_d    = 1'b0;
          era_d    = 1'b0;
          rst_d    = 1'b0;
          state_d  = RELEASE;
        end else begin
          pul_d = pul_q + 1'b1;
        end
      end
      default: begin
        if (sync_q == 3'b000) state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any pulse in progress on the same edge
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q  <= IDLE;
      sel_q    <= 3'b000;
      deb_q    <= '0;
      pul_q    <= '0;
      cuadro_q <= 9'd0;
      rnd_q    <= 1'b0;
      rst_q    <= 1'b0;
      era_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      deb_q    <= deb_d;
      pul_q    <= pul_d;
      cuadro_q <= cuadro_d;
      rnd_q    <= rnd_d;
      rst_q    <= rst_d;
      era_q    <= era_d;
    end
  end

  assign cuadro      = cuadro_q;
  assign randomClick = rnd_q;
  assign restart     = rst_q;
  assign erase       = era_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_click_to_cell_decoder.sv
// tb/tb_click_to_cell_decoder.sv - directed self-checking bench for click_to_cell_decoder
module tb_click_to_cell_decoder;

  logic       clk_100MHz;
  logic       reset;
  logic [9:0] mouse_x, mouse_y;
  logic       btn_left, btn_right, btn_middle;
  logic [8:0] cuadro;
  logic       randomClick, restart, erase, busy;

  int checks   = 0;
  int failures = 0;

  // Per-window statistics, cycle index 1 = first sample after the first rising edge
  int         cyc;
  int         first_k;
  int         n_rnd, n_rst, n_era, n_bad;
  logic [8:0] cuadro_or;

  click_to_cell_decoder #(
    .DEB_CYCLES(8),
    .PULSE_LEN (4),
    .X0        (220),
    .Y0        (140),
    .CELL      (66),
    .CW        (10)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .mouse_x    (mouse_x),
    .mouse_y    (mouse_y),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_middle (btn_middle),
    .cuadro     (cuadro),
    .randomClick(randomClick),
    .restart    (restart),
    .erase      (erase),
    .busy       (busy)
  );

  // 100 MHz clock
  always #5 clk_100MHz = ~clk_100MHz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    cyc = 0; first_k = -1;
    n_rnd = 0; n_rst = 0; n_era = 0; n_bad = 0;
    cuadro_or = 9'd0;
  endtask

  // Advance one clock and sample on the falling edge
  task automatic step();
    @(negedge clk_100MHz);
    cyc++;
    if (first_k < 0 && (randomClick || restart || erase)) first_k = cyc;
    if (randomClick) n_rnd++;
    if (restart)     n_rst++;
    if (erase)       n_era++;
    cuadro_or = cuadro_or | cuadro;
    if ((32'(randomClick) + 32'(restart) + 32'(erase)) > 1) n_bad++;
    if (cuadro != 9'd0 && !randomClick) n_bad++;
    if ($countones(cuadro) > 1) n_bad++;
  endtask

  // Press btns at (x,y) for hold cycles, optionally move the pointer at move_k, watch total cycles
  task automatic click(input logic [2:0] btns, input int x, input int y, input int hold,
                       input int total, input int move_k);
    clear_stats();
    mouse_x = 10'(x);
    mouse_y = 10'(y);
    {btn_right, btn_middle, btn_left} = btns;
    for (int k = 1; k <= total; k++) begin
      step();
      if (k == hold) {btn_right, btn_middle, btn_left} = 3'b000;
      if (k == move_k) begin
        mouse_x = 10'd230;
        mouse_y = 10'd150;
      end
    end
  endtask

  initial begin
    clk_100MHz = 1'b0;
    reset      = 1'b1;
    mouse_x    = 10'd320;
    mouse_y    = 10'd240;
    btn_left   = 1'b1;
    btn_right  = 1'b0;
    btn_middle = 1'b0;
    @(negedge clk_100MHz);

    // Reset held with the left button down
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_outputs", {19'd0, cuadro, randomClick, restart, erase, busy}, 32'd0);
    end
    reset = 1'b0;
    click(3'b001, 320, 240, 20, 40, 0);
    check("post_reset_first", first_k, 11);
    check("post_reset_len", n_rnd, 4);
    check("post_reset_cell", cuadro_or, 9'b000010000);

    // Centre click, pointer moved during the pulse
    click(3'b001, 320, 240, 20, 40, 12);
    check("centre_first", first_k, 11);
    check("centre_rnd_len", n_rnd, 4);
    check("centre_cell", cuadro_or, 9'b000010000);
    check("centre_other", n_rst + n_era, 0);
    check("centre_invariant", n_bad, 0);
    check("centre_idle", busy, 0);

    // Board edges
    click(3'b001, 220, 140, 12, 30, 0);
    check("edge_tl_cell", cuadro_or, 9'b000000001);
    check("edge_tl_rnd", n_rnd, 4);
    click(3'b001, 418, 140, 12, 30, 0);
    check("edge_right_out", cuadro_or, 9'b000000000);
    check("edge_right_rnd", n_rnd, 4);
    click(3'b001, 417, 337, 12, 30, 0);
    check("edge_br_cell", cuadro_or, 9'b100000000);
    check("edge_invariant", n_bad, 0);

    // Bounce: 5 high, 2 low, 5 high, then low
    clear_stats();
    btn_left = 1'b1;
    for (int i = 0; i < 5; i++) step();
    btn_left = 1'b0;
    for (int i = 0; i < 2; i++) step();
    btn_left = 1'b1;
    for (int i = 0; i < 5; i++) step();
    btn_left = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check("bounce_no_pulse", n_rnd + n_rst + n_era, 0);
    check("bounce_idle", busy, 0);

    // Left and right together: right wins
    click(3'b101, 320, 240, 20, 40, 0);
    check("prio_first", first_k, 11);
    check("prio_restart_len", n_rst, 4);
    check("prio_rnd", n_rnd, 0);
    check("prio_erase", n_era, 0);
    check("prio_cuadro", cuadro_or, 9'd0);

    // Reset during the second cycle of an erase pulse
    clear_stats();
    btn_middle = 1'b1;
    while (!erase && cyc < 30) step();
    check("midreset_seen", erase, 1);
    check("midreset_first", cyc, 11);
    step();
    check("midreset_2nd_cycle", erase, 1);
    reset      = 1'b1;
    btn_middle = 1'b0;
    step();
    check("midreset_cleared", {19'd0, cuadro, randomClick, restart, erase, busy}, 32'd0);
    step();
    reset = 1'b0;
    clear_stats();
    for (int i = 0; i < 30; i++) step();
    check("midreset_no_resume", n_rnd + n_rst + n_era, 0);
    click(3'b010, 320, 240, 20, 40, 0);
    check("midreset_new_press", n_era, 4);
    check("midreset_new_first", first_k, 11);
    check("midreset_invariant", n_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
